// File: rtl/bldcm_multi_ramp.sv
// ---------------------------------------------------------------------------
// bldcm_multi_ramp
// N-channel six-step BLDC gate-drive generator with an Avalon-MM register
// slave. Each channel owns a phase accumulator (NCO) whose carry-out steps a
// 12-entry commutation sequencer. Even stages drive a full six-step state.
// Odd stages keep only the switch shared by the two neighbouring states, so
// commutation is break-before-make in both directions. A shared prescaler
// paces per-channel acceleration ramps. Direction reversal always ramps
// through zero speed.
//
// Optional feature macro: BLDCM_BRAKE_EN. When defined, CTRL[2] is a brake
// that turns all low sides on and ramps the speed to zero.
//
// Ports
//   iClock            system clock
//   iReset_n          asynchronous active-low reset
//   iAddr[CW+2:0]     word address {channel, reg}
//   iRead / iWrite    Avalon-MM strobes, one access per cycle, no waitrequest
//   iWdata[31:0]      write data
//   oRdata[31:0]      registered read data, valid 1 cycle after iRead
//   oResp[1:0]        2'b00 OKAY, 2'b10 SLAVEERROR, valid 1 cycle after access
//   oUh..oWl          gate drives, bit n = channel n, XOR pInvert per leg
// ---------------------------------------------------------------------------
module bldcm_multi_ramp #(
    parameter int unsigned pChannels     = 2,
    parameter int unsigned pAccWidth     = 32,
    parameter int unsigned pRampPrescale = 1000,
    parameter logic [5:0]  pInvert       = 6'b000000,
    localparam int unsigned CW = (pChannels > 1) ? $clog2(pChannels) : 1
) (
    input  logic                 iClock,
    input  logic                 iReset_n,
    input  logic [CW+2:0]        iAddr,
    input  logic                 iRead,
    output logic [31:0]          oRdata,
    input  logic                 iWrite,
    input  logic [31:0]          iWdata,
    output logic [1:0]           oResp,
    output logic [pChannels-1:0] oUh,
    output logic [pChannels-1:0] oUl,
    output logic [pChannels-1:0] oVh,
    output logic [pChannels-1:0] oVl,
    output logic [pChannels-1:0] oWh,
    output logic [pChannels-1:0] oWl
);

    localparam logic [2:0] REG_CTRL    = 3'd0;
    localparam logic [2:0] REG_TARGET  = 3'd1;
    localparam logic [2:0] REG_RAMP    = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CURRATE = 3'd4;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned PW = (pRampPrescale > 1) ? $clog2(pRampPrescale) : 1;

    // Leg order in every 6-bit gate word: {Wl,Wh,Vl,Vh,Ul,Uh}.
    localparam logic [5:0] GATE_BRAKE = 6'b101010;

    // Commutation table. Odd entries keep only the switch common to both
    // neighbouring six-step states.
    function automatic logic [5:0] decodeStage(input logic [3:0] stage);
        logic [5:0] g;
        case (stage)
            4'd0:    g = 6'b001001; // Uh Vl
            4'd1:    g = 6'b000001; // Uh
            4'd2:    g = 6'b100001; // Uh Wl
            4'd3:    g = 6'b100000; // Wl
            4'd4:    g = 6'b100100; // Vh Wl
            4'd5:    g = 6'b000100; // Vh
            4'd6:    g = 6'b000110; // Vh Ul
            4'd7:    g = 6'b000010; // Ul
            4'd8:    g = 6'b010010; // Wh Ul
            4'd9:    g = 6'b010000; // Wh
            4'd10:   g = 6'b011000; // Wh Vl
            4'd11:   g = 6'b001000; // Vl
            default: g = 6'b000000;
        endcase
        return g;
    endfunction

    logic [2:0]    addrReg_s;
    logic [CW-1:0] addrCh_s;
    logic          chValid_s;
    logic          rampPulse_s;
    logic [PW-1:0] preCnt_r;
    logic [31:0]   rdWord_s [pChannels];
    logic [31:0]   rdSel_s;
    logic          rdOk_s;
    logic          wrOk_s;

    assign addrReg_s = iAddr[2:0];
    assign addrCh_s  = iAddr[CW+2:3];
    assign chValid_s = (32'(addrCh_s) < pChannels);

    assign rampPulse_s = (preCnt_r == PW'(pRampPrescale - 1));

    // Shared ramp prescaler, one pulse every pRampPrescale cycles.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            preCnt_r <= '0;
        end else if (rampPulse_s) begin
            preCnt_r <= '0;
        end else begin
            preCnt_r <= preCnt_r + PW'(1);
        end
    end

    // Per-channel control, ramp, NCO, sequencer and registered gate drive.
    for (genvar c = 0; c < pChannels; c++) begin : gCh
        logic                 enable_r;
        logic                 dirReq_r;
        logic                 dirEff_r;
        logic                 brake_s;
        logic [pAccWidth-1:0] target_r;
        logic [pAccWidth-1:0] rateCur_r;
        logic [pAccWidth-1:0] acc_r;
        logic [15:0]          ramp_r;
        logic [3:0]           stage_r;
        logic [5:0]           gate_r;
        logic [pAccWidth-1:0] goal_s;
        logic [pAccWidth-1:0] diff_s;
        logic [pAccWidth-1:0] rateNext_s;
        logic [pAccWidth:0]   accSum_s;
        logic [3:0]           stageStep_s;
        logic [5:0]           gateDec_s;
        logic                 wrSel_s;
        logic                 stageWr_s;
        logic                 atTarget_s;
        logic [31:0]          rd_s;

`ifdef BLDCM_BRAKE_EN
        logic brake_r;
        assign brake_s = brake_r;

        // Brake bit, written together with the rest of CTRL.
        always_ff @(posedge iClock or negedge iReset_n) begin
            if (!iReset_n) begin
                brake_r <= 1'b0;
            end else if (wrSel_s && (addrReg_s == REG_CTRL)) begin
                brake_r <= iWdata[2];
            end else begin
                brake_r <= brake_r;
            end
        end
`else
        assign brake_s = 1'b0;
`endif

        assign wrSel_s    = iWrite && chValid_s && (addrCh_s == CW'(c));
        assign stageWr_s  = wrSel_s && (addrReg_s == REG_STATUS) && (iWdata[3:0] < 4'd12);
        assign accSum_s   = {1'b0, acc_r} + {1'b0, rateCur_r};
        assign atTarget_s = (dirEff_r == dirReq_r) && (rateCur_r == target_r);

        // Next ramp rate: step toward the goal, never overshooting it.
        // A pending reversal or the brake forces the goal to zero.
        always_comb begin
            goal_s     = ((dirReq_r != dirEff_r) || brake_s) ? '0 : target_r;
            diff_s     = '0;
            rateNext_s = rateCur_r;
            if (goal_s > rateCur_r) begin
                diff_s = goal_s - rateCur_r;
                if ((ramp_r == 16'd0) || (pAccWidth'(ramp_r) >= diff_s)) begin
                    rateNext_s = goal_s;
                end else begin
                    rateNext_s = rateCur_r + pAccWidth'(ramp_r);
                end
            end else if (goal_s < rateCur_r) begin
                diff_s = rateCur_r - goal_s;
                if ((ramp_r == 16'd0) || (pAccWidth'(ramp_r) >= diff_s)) begin
                    rateNext_s = goal_s;
                end else begin
                    rateNext_s = rateCur_r - pAccWidth'(ramp_r);
                end
            end else begin
                rateNext_s = rateCur_r;
            end
        end

        // Sequencer step with wrap in the effective direction.
        always_comb begin
            if (!dirEff_r) begin
                stageStep_s = (stage_r == 4'd11) ? 4'd0 : stage_r + 4'd1;
            end else begin
                stageStep_s = (stage_r == 4'd0) ? 4'd11 : stage_r - 4'd1;
            end
        end

        // Gate pattern before polarity: off, brake, or commutation table.
        always_comb begin
            if (!enable_r) begin
                gateDec_s = 6'b000000;
            end else if (brake_s) begin
                gateDec_s = GATE_BRAKE;
            end else begin
                gateDec_s = decodeStage(stage_r);
            end
        end

        // Register read word for the addressed register of this channel.
        always_comb begin
            case (addrReg_s)
                REG_CTRL:    rd_s = {29'd0, brake_s, dirReq_r, enable_r};
                REG_TARGET:  rd_s = 32'(target_r);
                REG_RAMP:    rd_s = {16'd0, ramp_r};
                REG_STATUS:  rd_s = {25'd0, (rateCur_r == '0), dirEff_r, atTarget_s, stage_r};
                REG_CURRATE: rd_s = 32'(rateCur_r);
                default:     rd_s = 32'd0;
            endcase
        end

        // Channel state. Ramp and NCO use register values from before this
        // edge, so a same-cycle TARGET write is seen only by the next pulse.
        // A valid STATUS write overrides an NCO carry in the same cycle.
        always_ff @(posedge iClock or negedge iReset_n) begin
            if (!iReset_n) begin
                enable_r  <= 1'b0;
                dirReq_r  <= 1'b0;
                dirEff_r  <= 1'b0;
                target_r  <= '0;
                ramp_r    <= 16'd0;
                rateCur_r <= '0;
                acc_r     <= '0;
                stage_r   <= 4'd0;
                gate_r    <= pInvert;
            end else begin
                if (wrSel_s && (addrReg_s == REG_CTRL)) begin
                    enable_r <= iWdata[0];
                    dirReq_r <= iWdata[1];
                end
                if (wrSel_s && (addrReg_s == REG_TARGET)) begin
                    target_r <= iWdata[pAccWidth-1:0];
                end
                if (wrSel_s && (addrReg_s == REG_RAMP)) begin
                    ramp_r <= iWdata[15:0];
                end

                if (!enable_r) begin
                    rateCur_r <= '0;
                    acc_r     <= '0;
                    dirEff_r  <= dirReq_r;
                end else begin
                    acc_r <= accSum_s[pAccWidth-1:0];
                    if (rampPulse_s) begin
                        rateCur_r <= rateNext_s;
                        if ((rateCur_r == '0) && (dirReq_r != dirEff_r)) begin
                            dirEff_r <= dirReq_r;
                        end
                    end
                end

                if (stageWr_s) begin
                    stage_r <= iWdata[3:0];
                end else if (enable_r && accSum_s[pAccWidth]) begin
                    stage_r <= stageStep_s;
                end

                gate_r <= gateDec_s ^ pInvert;
            end
        end

        assign rdWord_s[c] = rd_s;
        assign oUh[c] = gate_r[0];
        assign oUl[c] = gate_r[1];
        assign oVh[c] = gate_r[2];
        assign oVl[c] = gate_r[3];
        assign oWh[c] = gate_r[4];
        assign oWl[c] = gate_r[5];
    end

    // Channel select for read data.
    always_comb begin
        rdSel_s = 32'd0;
        for (int c = 0; c < int'(pChannels); c++) begin
            if (addrCh_s == CW'(c)) begin
                rdSel_s = rdWord_s[c];
            end else begin
                rdSel_s = rdSel_s;
            end
        end
    end

    assign rdOk_s = chValid_s && (addrReg_s <= REG_CURRATE);
    assign wrOk_s = chValid_s && ((addrReg_s < REG_STATUS) || (addrReg_s == REG_CURRATE) ||
                                  ((addrReg_s == REG_STATUS) && (iWdata[3:0] < 4'd12)));

    // Registered bus response; data is zero except for a successful read.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            oRdata <= 32'd0;
            oResp  <= RESP_OKAY;
        end else if (iRead) begin
            oRdata <= rdOk_s ? rdSel_s : 32'd0;
            oResp  <= rdOk_s ? RESP_OKAY : RESP_SLVERR;
        end else if (iWrite) begin
            oRdata <= 32'd0;
            oResp  <= wrOk_s ? RESP_OKAY : RESP_SLVERR;
        end else begin
            oRdata <= 32'd0;
            oResp  <= RESP_OKAY;
        end
    end

endmodule

// File: tb/tb_bldcm_multi_ramp.sv
// ---------------------------------------------------------------------------
// tb_bldcm_multi_ramp
// Scoreboard bench for bldcm_multi_ramp: 3 channels, 16-bit accumulator,
// ramp prescale 4, Uh/Ul legs inverted. Expected values are queued when the
// stimulus is applied and popped when the DUT output appears.
// ---------------------------------------------------------------------------
module tb_bldcm_multi_ramp;

    localparam int         NCH = 3;
    localparam int         AW  = 16;
    localparam int         PRE = 4;
    localparam logic [5:0] INV = 6'b000011;

    logic             iClock = 1'b0;
    logic             iReset_n = 1'b0;
    logic [4:0]       iAddr = 5'd0;
    logic             iRead = 1'b0;
    logic [31:0]      oRdata;
    logic             iWrite = 1'b0;
    logic [31:0]      iWdata = 32'd0;
    logic [1:0]       oResp;
    logic [NCH-1:0]   oUh, oUl, oVh, oVl, oWh, oWl;

    int compareCnt = 0;
    int mismatchCnt = 0;

    logic [33:0] expQ [$];
    logic [31:0] chgQ [$];

    // Six-step table {Wl,Wh,Vl,Vh,Ul,Uh} for stages 0..11.
    logic [5:0] stTab [12] = '{6'b001001, 6'b000001, 6'b100001, 6'b100000,
                               6'b100100, 6'b000100, 6'b000110, 6'b000010,
                               6'b010010, 6'b010000, 6'b011000, 6'b001000};

    bldcm_multi_ramp #(
        .pChannels(NCH), .pAccWidth(AW), .pRampPrescale(PRE), .pInvert(INV)
    ) dut (
        .iClock(iClock), .iReset_n(iReset_n), .iAddr(iAddr), .iRead(iRead),
        .oRdata(oRdata), .iWrite(iWrite), .iWdata(iWdata), .oResp(oResp),
        .oUh(oUh), .oUl(oUl), .oVh(oVh), .oVl(oVl), .oWh(oWh), .oWl(oWl)
    );

    always #5 iClock = ~iClock;

    function automatic logic [5:0] pins(input int c);
        return {oWl[c], oWh[c], oVl[c], oVh[c], oUl[c], oUh[c]};
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCnt++;
        if (obs !== exp) begin
            mismatchCnt++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic busRead(input logic [1:0] ch, input logic [2:0] r,
                           output logic [31:0] d, output logic [1:0] rp);
        @(negedge iClock);
        iAddr = {ch, r};
        iRead = 1'b1;
        @(negedge iClock);
        iRead = 1'b0;
        d  = oRdata;
        rp = oResp;
    endtask

    task automatic expectRead(input string tag, input logic [1:0] ch, input logic [2:0] r,
                              input logic [31:0] expD, input logic [1:0] expR);
        logic [31:0] d;
        logic [1:0]  rp;
        logic [33:0] e;
        expQ.push_back({expR, expD});
        busRead(ch, r, d, rp);
        e = expQ.pop_front();
        checkVal({tag, ".data"}, d, e[31:0]);
        checkVal({tag, ".resp"}, 32'(rp), 32'(e[33:32]));
    endtask

    task automatic busWrite(input string tag, input logic [1:0] ch, input logic [2:0] r,
                            input logic [31:0] data, input logic [1:0] expR);
        logic [33:0] e;
        expQ.push_back({expR, 32'd0});
        @(negedge iClock);
        iAddr  = {ch, r};
        iWdata = data;
        iWrite = 1'b1;
        @(negedge iClock);
        iWrite = 1'b0;
        e = expQ.pop_front();
        checkVal({tag, ".resp"}, 32'(oResp), 32'(e[33:32]));
    endtask

    // Poll CURRATE and compare each change against chgQ; optionally check
    // the spacing between changes (reads are 2 cycles apart).
    task automatic pollRate(input string tag, input logic [1:0] ch,
                            input logic [31:0] startVal, input int expInterval);
        logic [31:0] d, prev, e;
        logic [1:0]  rp;
        int lastT = 0;
        int n = 0;
        prev = startVal;
        for (int cyc = 0; cyc < 200 && chgQ.size() > 0; cyc++) begin
            busRead(ch, 3'd4, d, rp);
            if (d != prev) begin
                e = chgQ.pop_front();
                checkVal($sformatf("%s.rate%0d", tag, n), d, e);
                if (expInterval > 0 && n > 0)
                    checkVal($sformatf("%s.interval%0d", tag, n), 32'((cyc - lastT) * 2), 32'(expInterval));
                lastT = cyc;
                prev = d;
                n++;
            end
        end
        checkVal({tag, ".timeout"}, 32'(chgQ.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  rp;
        logic [33:0] e;
        logic [5:0]  prevP, curP;
        logic [3:0]  prevS, s, expS;
        int lastT, n;
        logic wrapSeen;

        // Reset state
        repeat (2) @(negedge iClock);
        for (int c = 0; c < NCH; c++)
            checkVal($sformatf("reset.pins%0d", c), 32'(pins(c)), 32'(INV));
        checkVal("reset.rdata", oRdata, 32'd0);
        checkVal("reset.resp", 32'(oResp), 32'd0);
        iReset_n = 1'b1;
        expectRead("reset.ctrl", 2'd0, 3'd0, 32'd0, 2'b00);
        expectRead("reset.target", 2'd0, 3'd1, 32'd0, 2'b00);
        // STATUS at reset: stopped (rate 0) and at_target (0 == TARGET 0).
        expectRead("reset.status", 2'd0, 3'd3, 32'h50, 2'b00);

        // ch0: jump to rate 2^(AW-4), stage every 16 cycles
        busWrite("ch0.wrRamp", 2'd0, 3'd2, 32'd0, 2'b00);
        busWrite("ch0.wrTarget", 2'd0, 3'd1, 32'd4096, 2'b00);
        busWrite("ch0.wrCtrl", 2'd0, 3'd0, 32'd1, 2'b00);
        for (int k = 0; k < 12; k++) expQ.push_back(34'(stTab[k] ^ INV));
        expQ.push_back(34'(stTab[0] ^ INV));
        prevP = pins(0);
        lastT = 0;
        n = 0;
        for (int cyc = 0; cyc < 600 && expQ.size() > 0; cyc++) begin
            @(negedge iClock);
            curP = pins(0);
            if (curP != prevP) begin
                e = expQ.pop_front();
                checkVal($sformatf("ch0.pattern%0d", n), 32'(curP), e[31:0]);
                if (n >= 2) checkVal($sformatf("ch0.interval%0d", n), 32'(cyc - lastT), 32'd16);
                if (n % 2 == 1 && n < 12)
                    checkVal($sformatf("ch0.oddOnes%0d", n), 32'($countones(curP ^ INV)), 32'd1);
                lastT = cyc;
                prevP = curP;
                n++;
            end
        end
        checkVal("ch0.patternTimeout", 32'(expQ.size()), 32'd0);
        expQ.delete();
        checkVal("ch1.pinsIdle", 32'(pins(1)), 32'(INV));

        // ch0 reversal through zero
        busWrite("rev.wrRamp", 2'd0, 3'd2, 32'd2048, 2'b00);
        busWrite("rev.wrCtrl", 2'd0, 3'd0, 32'd3, 2'b00);
        chgQ.push_back(32'd2048); chgQ.push_back(32'd0);
        chgQ.push_back(32'd2048); chgQ.push_back(32'd4096);
        pollRate("rev", 2'd0, 32'd4096, 0);
        busRead(2'd0, 3'd3, d, rp);
        checkVal("rev.statusBits", (d >> 4) & 32'd7, 32'd3);
        busRead(2'd0, 3'd3, d, rp);
        prevS = d[3:0];
        wrapSeen = 1'b0;
        for (int cyc = 0; cyc < 200 && !wrapSeen; cyc++) begin
            busRead(2'd0, 3'd3, d, rp);
            s = d[3:0];
            if (s != prevS) begin
                expS = (prevS == 4'd0) ? 4'd11 : prevS - 4'd1;
                checkVal("rev.stageDec", 32'(s), 32'(expS));
                if (prevS == 4'd0 && s == 4'd11) wrapSeen = 1'b1;
                prevS = s;
            end
        end
        checkVal("rev.wrapSeen", 32'(wrapSeen), 32'd1);

        // ch1 ramp 5 per tick to 20
        busWrite("ch1.wrTarget", 2'd1, 3'd1, 32'd20, 2'b00);
        busWrite("ch1.wrRamp", 2'd1, 3'd2, 32'd5, 2'b00);
        busWrite("ch1.wrCtrl", 2'd1, 3'd0, 32'd1, 2'b00);
        chgQ.push_back(32'd5); chgQ.push_back(32'd10);
        chgQ.push_back(32'd15); chgQ.push_back(32'd20);
        pollRate("ch1", 2'd1, 32'd0, PRE);
        expectRead("ch1.status", 2'd1, 3'd3, 32'h10, 2'b00);
        expectRead("ch0.rateKept", 2'd0, 3'd4, 32'd4096, 2'b00);
        checkVal("ch1.pinsS0", 32'(pins(1)), 32'(stTab[0] ^ INV));
        checkVal("ch2.pinsIdle", 32'(pins(2)), 32'(INV));

`ifdef BLDCM_BRAKE_EN
        busWrite("brk.wrCtrl", 2'd1, 3'd0, 32'd5, 2'b00);
        @(negedge iClock);
        checkVal("brk.pins", 32'(pins(1)), 32'(6'b101010 ^ INV));
        chgQ.push_back(32'd15); chgQ.push_back(32'd10);
        chgQ.push_back(32'd5);  chgQ.push_back(32'd0);
        pollRate("brk", 2'd1, 32'd20, PRE);
        busWrite("brk.release", 2'd1, 3'd0, 32'd1, 2'b00);
        chgQ.push_back(32'd5);  chgQ.push_back(32'd10);
        chgQ.push_back(32'd15); chgQ.push_back(32'd20);
        pollRate("brkRel", 2'd1, 32'd0, PRE);
`endif

        // Error responses and stage load
        busWrite("err.disable", 2'd0, 3'd0, 32'd0, 2'b00);
        busRead(2'd0, 3'd3, d, rp);
        s = d[3:0];
        busWrite("err.status12", 2'd0, 3'd3, 32'd12, 2'b10);
        expectRead("err.stageHeld", 2'd0, 3'd3, 32'h40 | 32'(s), 2'b00);
        busWrite("err.status7", 2'd0, 3'd3, 32'd7, 2'b00);
        expectRead("err.stage7", 2'd0, 3'd3, 32'h47, 2'b00);
        checkVal("err.pinsOff", 32'(pins(0)), 32'(INV));
        expectRead("err.reg6", 2'd0, 3'd6, 32'd0, 2'b10);
        expectRead("err.ch3", 2'd3, 3'd0, 32'd0, 2'b10);
        busWrite("err.wrCh3", 2'd3, 3'd1, 32'd99, 2'b10);
        busWrite("err.wrReg5", 2'd1, 3'd5, 32'd99, 2'b10);
        expectRead("ch1.ctrl", 2'd1, 3'd0, 32'd1, 2'b00);
        expectRead("ch1.target", 2'd1, 3'd1, 32'd20, 2'b00);

        // Asynchronous reset mid-operation
        @(negedge iClock);
        #2 iReset_n = 1'b0;
        #1;
        for (int c = 0; c < NCH; c++)
            checkVal($sformatf("areset.pins%0d", c), 32'(pins(c)), 32'(INV));
        @(negedge iClock);
        iReset_n = 1'b1;
        expectRead("areset.rate1", 2'd1, 3'd4, 32'd0, 2'b00);
        expectRead("areset.ctrl1", 2'd1, 3'd0, 32'd0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
        $finish;
    end

endmodule
